// File: rtl/cellrv32_npu_package.sv
// cellrv32_npu_package: NPU instruction types, opcode class bits, dispatch classes and FSM states.
package cellrv32_npu_package;

    localparam logic [7:0] NPU_OP_SYNC    = 8'hFF;
    localparam int         NPU_ACT_BIT    = 7;
    localparam int         NPU_MATRIX_BIT = 5;
    localparam int         NPU_WEIGHT_BIT = 3;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] calc_length;
        logic [15:0] op_address;
        logic [31:0] buffer_address;
    } instruction_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] calc_length;
        logic [15:0] weight_address;
        logic [31:0] buffer_address;
    } weight_instruction_t;

    typedef enum logic [2:0] {NOP, WEIGHT, MATRIX, ACT, SYNC} npu_disp_class_t;
    typedef enum logic {IDLE, SYNC_WAIT} npu_disp_state_t;

    function automatic weight_instruction_t to_weight_instruction(input instruction_t i);
        return '{opcode: i.opcode, calc_length: i.calc_length,
                 weight_address: i.op_address, buffer_address: i.buffer_address};
    endfunction

    function automatic npu_disp_class_t npu_decode_class(input logic [7:0] opcode);
        return opcode == NPU_OP_SYNC    ? SYNC   :
               opcode[NPU_ACT_BIT]      ? ACT    :
               opcode[NPU_MATRIX_BIT]   ? MATRIX :
               opcode[NPU_WEIGHT_BIT]   ? WEIGHT : NOP;
    endfunction

endpackage

// File: rtl/cellrv32_npu_inst_fifo.sv
// cellrv32_npu_inst_fifo: power-of-two instruction queue with registered head, level and flush.
module cellrv32_npu_inst_fifo
    import cellrv32_npu_package::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  instruction_t             data_i,
    input  logic                     pop_i,
    output instruction_t             head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    instruction_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     level_q;
    logic            do_push, do_pop;

    assign empty_o = level_q == '0;
    assign full_o  = level_q == (AW+1)'(DEPTH);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/cellrv32_npu_dispatch_coordinator.sv
// cellrv32_npu_dispatch_coordinator: queued NPU dispatch with SYNC watchdog; CELLRV32_NPU_DISPATCH_PERF_EN adds perf counters.
module cellrv32_npu_dispatch_coordinator
    import cellrv32_npu_package::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_TIMEOUT = 1024
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          enable_i,
    input  logic                          flush_i,
    input  instruction_t                  inst_i,
    input  logic                          inst_valid_i,
    output logic                          inst_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    input  logic                          wei_busy_i,
    input  logic                          wei_resource_busy_i,
    output weight_instruction_t           wei_inst_o,
    output logic                          wei_inst_en_o,
    input  logic                          matrix_busy_i,
    input  logic                          matrix_resource_busy_i,
    output instruction_t                  matrix_inst_o,
    output logic                          matrix_inst_en_o,
    input  logic                          activation_busy_i,
    input  logic                          activation_resource_busy_i,
    output instruction_t                  activation_inst_o,
    output logic                          activation_inst_en_o,
    output logic                          syn_o,
    output logic                          timeout_o
`ifdef CELLRV32_NPU_DISPATCH_PERF_EN
    ,
    output logic [31:0]                   perf_issue_cnt_o,
    output logic [31:0]                   perf_stall_cnt_o
`endif
);

    localparam int              CW   = SYNC_TIMEOUT > 0 ? $clog2(SYNC_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   TMAX = CW'(SYNC_TIMEOUT);

    instruction_t       head;
    logic               empty, full, pop, head_go, res_busy;
    logic               wei_go, mat_go, act_go, syn_go;
    npu_disp_class_t    cls;
    npu_disp_state_t    state_q;
    logic [CW-1:0]      count_q;
    logic               timeout_q;

    cellrv32_npu_inst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (flush_i),
        .push_i  (inst_valid_i && inst_ready_o),
        .data_i  (inst_i),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (empty),
        .full_o  (full),
        .level_o (fifo_level_o)
    );

    assign inst_ready_o      = !full && !flush_i;
    assign cls               = npu_decode_class(head.opcode);
    assign head_go           = !empty && enable_i && !flush_i;
    assign res_busy          = wei_resource_busy_i || matrix_resource_busy_i || activation_resource_busy_i;
    assign wei_inst_o        = to_weight_instruction(head);
    assign matrix_inst_o     = head;
    assign activation_inst_o = head;

    always_comb begin
        wei_go = head_go && state_q == IDLE && cls == WEIGHT && !wei_busy_i;
        mat_go = head_go && state_q == IDLE && cls == MATRIX && !matrix_busy_i;
        act_go = head_go && state_q == IDLE && cls == ACT && !matrix_busy_i && !activation_busy_i;
        syn_go = head_go && state_q == SYNC_WAIT && !res_busy;
        pop    = wei_go || mat_go || act_go || syn_go || (head_go && state_q == IDLE && cls == NOP);
    end

    assign wei_inst_en_o        = wei_go;
    assign matrix_inst_en_o     = mat_go;
    assign activation_inst_en_o = act_go;
    assign syn_o                = syn_go;
    assign timeout_o            = timeout_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else if (flush_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else if (head_go) begin
            if (state_q == IDLE) begin
                if (cls == SYNC) begin
                    state_q <= SYNC_WAIT;
                    count_q <= '0;
                end
            end else if (!res_busy) begin
                state_q <= IDLE;
            end else if (count_q != TMAX) begin
                count_q   <= count_q + 1'b1;
                timeout_q <= timeout_q || (count_q + 1'b1 == TMAX);
            end
        end
    end

`ifdef CELLRV32_NPU_DISPATCH_PERF_EN
    logic [31:0] issue_q, stall_q;

    assign perf_issue_cnt_o = issue_q;
    assign perf_stall_cnt_o = stall_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            issue_q <= '0;
            stall_q <= '0;
        end else if (flush_i) begin
            issue_q <= '0;
            stall_q <= '0;
        end else begin
            issue_q <= issue_q + 32'(wei_go || mat_go || act_go || syn_go);
            stall_q <= stall_q + 32'(head_go && !pop);
        end
    end
`endif

endmodule

// File: tb/tb_cellrv32_npu_dispatch_coordinator.sv
// tb_cellrv32_npu_dispatch_coordinator: directed scenarios plus randomized traffic against a queue-level model.
module tb_cellrv32_npu_dispatch_coordinator;
    import cellrv32_npu_package::*;

    localparam int D  = 4;
    localparam int TO = 20;

    logic clk = 0, rstn = 0;
    logic enable = 0, flush = 0, valid = 0;
    logic wb = 0, wrb = 0, mb = 0, mrb = 0, ab = 0, arb = 0;
    instruction_t inst = '0;
    logic ready, wei_en, mat_en, act_en, syn, tmo_o;
    logic [2:0] level;
    weight_instruction_t wei_inst;
    instruction_t mat_inst, act_inst;
`ifdef CELLRV32_NPU_DISPATCH_PERF_EN
    logic [31:0] perf_issue, perf_stall;
`endif

    int nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    cellrv32_npu_dispatch_coordinator #(.FIFO_DEPTH(D), .SYNC_TIMEOUT(TO)) dut (
        .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .flush_i(flush),
        .inst_i(inst), .inst_valid_i(valid), .inst_ready_o(ready), .fifo_level_o(level),
        .wei_busy_i(wb), .wei_resource_busy_i(wrb), .wei_inst_o(wei_inst), .wei_inst_en_o(wei_en),
        .matrix_busy_i(mb), .matrix_resource_busy_i(mrb), .matrix_inst_o(mat_inst), .matrix_inst_en_o(mat_en),
        .activation_busy_i(ab), .activation_resource_busy_i(arb), .activation_inst_o(act_inst),
        .activation_inst_en_o(act_en), .syn_o(syn), .timeout_o(tmo_o)
`ifdef CELLRV32_NPU_DISPATCH_PERF_EN
        , .perf_issue_cnt_o(perf_issue), .perf_stall_cnt_o(perf_stall)
`endif
    );

    task automatic chk(input string n, input logic [95:0] a, input logic [95:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic int cls_of(input logic [7:0] op);
        if (op == 8'hFF) return 4;
        if (op[7]) return 3;
        if (op[5]) return 2;
        if (op[3]) return 1;
        return 0;
    endfunction

    function automatic instruction_t mk(input logic [7:0] op, input logic [15:0] a);
        instruction_t r;
        r.opcode = op;
        r.calc_length = 16'($urandom);
        r.op_address = a;
        r.buffer_address = $urandom;
        return r;
    endfunction

    instruction_t q[$];
    bit waiting, tmo;
    int wcnt, c, n;
    logic [31:0] pi, ps;
    bit ready_e, we, me, ae, se, pop_e, res;
    instruction_t h;

    always @(negedge clk) begin
        if (!rstn) begin
            q.delete(); waiting = 0; wcnt = 0; tmo = 0; pi = 0; ps = 0;
            chk("rst_ready", ready, 1);
            chk("rst_level", level, 0);
            chk("rst_en", {wei_en, mat_en, act_en, syn}, 0);
            chk("rst_timeout", tmo_o, 0);
        end else begin
            n = q.size();
            ready_e = n < D && !flush;
            res = wrb || mrb || arb;
            {we, me, ae, se} = 0;
            c = 0;
            if (n > 0) begin
                h = q[0];
                c = cls_of(h.opcode);
                if (enable && !flush) begin
                    if (waiting) se = !res;
                    else begin
                        we = c == 1 && !wb;
                        me = c == 2 && !mb;
                        ae = c == 3 && !mb && !ab;
                    end
                end
            end
            pop_e = we || me || ae || se || (n > 0 && enable && !flush && !waiting && c == 0);
            chk("ready", ready, ready_e);
            chk("level", level, n);
            chk("wei_en", wei_en, we);
            chk("mat_en", mat_en, me);
            chk("act_en", act_en, ae);
            chk("syn", syn, se);
            chk("timeout", tmo_o, tmo);
            if (n > 0) begin
                chk("mat_inst", mat_inst, h);
                chk("act_inst", act_inst, h);
                chk("wei_inst", wei_inst, {h.opcode, h.calc_length, h.op_address, h.buffer_address});
            end
`ifdef CELLRV32_NPU_DISPATCH_PERF_EN
            chk("perf_issue", perf_issue, pi);
            chk("perf_stall", perf_stall, ps);
`endif
            if (flush) begin
                q.delete(); waiting = 0; wcnt = 0; tmo = 0; pi = 0; ps = 0;
            end else begin
                pi += 32'(we || me || ae || se);
                if (n > 0 && enable && !pop_e) ps++;
                if (pop_e) void'(q.pop_front());
                if (valid && ready_e) q.push_back(inst);
                if (n > 0 && enable) begin
                    if (!waiting && c == 4) begin
                        waiting = 1; wcnt = 0;
                    end else if (waiting && !res) waiting = 0;
                    else if (waiting && wcnt < TO) begin
                        wcnt++;
                        if (wcnt == TO) tmo = 1;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable = 1; flush = 0; valid = 0;
        {wb, wrb, mb, mrb, ab, arb} = 0;
    endtask

    initial begin
        cyc(); cyc();
        rstn = 1;
        // 1: back-to-back weight, matrix, activation
        cyc(); idle(); valid = 1; inst = mk(8'h08, 1);
        @(negedge clk); chk("t1_c0_wen", wei_en, 0); chk("t1_c0_lvl", level, 0);
        cyc(); inst = mk(8'h20, 2);
        @(negedge clk); chk("t1_wen", wei_en, 1); chk("t1_c1_lvl", level, 1);
        cyc(); inst = mk(8'h80, 3);
        @(negedge clk); chk("t1_men", mat_en, 1); chk("t1_c2_lvl", level, 1);
        cyc(); valid = 0;
        @(negedge clk); chk("t1_aen", act_en, 1);
        cyc();
        @(negedge clk); chk("t1_lvl0", level, 0); chk("t1_aen0", act_en, 0);
        // 2: activation stalled behind matrix_busy
        cyc(); idle(); mb = 1; valid = 1; inst = mk(8'h80, 4);
        for (int i = 0; i < 5; i++) begin
            cyc(); valid = 0;
            @(negedge clk); chk("t2_stall", act_en, 0);
        end
        cyc(); mb = 0;
        @(negedge clk); chk("t2_aen", act_en, 1);
        // 3: fill with dispatch disabled, refuse the fifth, drain in order
        cyc(); idle(); enable = 0; valid = 1;
        for (int i = 0; i < 5; i++) begin
            inst = mk(8'h08, 16'(i));
            @(negedge clk);
            if (i == 4) begin chk("t3_ready", ready, 0); chk("t3_lvl4", level, 4); end
            cyc();
        end
        valid = 0; enable = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("t3_wen", wei_en, 1); chk("t3_order", wei_inst.weight_address, i);
            cyc();
        end
        @(negedge clk); chk("t3_lvl0", level, 0);
        // 4: SYNC watchdog
        cyc(); idle(); wrb = 1; valid = 1; inst = mk(8'hFF, 0);
        cyc(); valid = 0;
        for (int k = 1; k <= TO + 3; k++) begin
            @(negedge clk);
            if (k == TO + 1) chk("t4_tmo_pre", tmo_o, 0);
            if (k == TO + 2) chk("t4_tmo_set", tmo_o, 1);
            cyc();
        end
        wrb = 0;
        @(negedge clk); chk("t4_syn", syn, 1);
        cyc();
        @(negedge clk); chk("t4_syn_once", syn, 0); chk("t4_tmo_sticky", tmo_o, 1); chk("t4_lvl", level, 0);
        // 5: flush during SYNC_WAIT with three entries
        cyc(); idle(); flush = 1;
        cyc(); flush = 0; arb = 1; valid = 1; inst = mk(8'hFF, 0);
        cyc(); inst = mk(8'h08, 1);
        cyc(); inst = mk(8'h20, 2);
        cyc(); valid = 0;
        for (int k = 0; k < TO + 2; k++) cyc();
        @(negedge clk); chk("t5_tmo", tmo_o, 1); chk("t5_lvl3", level, 3);
        cyc(); flush = 1; valid = 1; inst = mk(8'h08, 9);
        @(negedge clk); chk("t5_nosyn", syn, 0); chk("t5_ready", ready, 0);
        cyc(); flush = 0; inst = mk(8'h08, 7);
        @(negedge clk); chk("t5_lvl0", level, 0); chk("t5_tmo0", tmo_o, 0);
        cyc(); valid = 0;
        @(negedge clk); chk("t5_idle_wen", wei_en, 1);
        // 6: NOP popped silently, then WEIGHT
        cyc(); idle(); flush = 1;
        cyc(); flush = 0; valid = 1; inst = mk(8'h00, 0);
        cyc(); inst = mk(8'h08, 5);
        @(negedge clk); chk("t6_nop_silent", {wei_en, mat_en, act_en, syn}, 0); chk("t6_lvl", level, 1);
        cyc(); valid = 0;
        @(negedge clk); chk("t6_wen", wei_en, 1); chk("t6_wei_addr", wei_inst.weight_address, 5);
        cyc();
        @(negedge clk); chk("t6_wen0", wei_en, 0);
`ifdef CELLRV32_NPU_DISPATCH_PERF_EN
        chk("t6_issue", perf_issue, 1); chk("t6_stall", perf_stall, 0);
`endif
        // randomized traffic with one asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rstn = i != 1500;
            flush = $urandom_range(0, 49) == 0;
            valid = $urandom_range(0, 2) != 0;
            case ($urandom_range(0, 5))
                0: inst = mk(8'h00, 16'(i));
                1: inst = mk(8'h08, 16'(i));
                2: inst = mk(8'h20, 16'(i));
                3: inst = mk(8'h80, 16'(i));
                4: inst = mk(8'hFF, 16'(i));
                default: inst = mk(8'($urandom), 16'(i));
            endcase
            enable = $urandom_range(0, 7) != 0;
            wb = $urandom_range(0, 3) == 0;
            mb = $urandom_range(0, 3) == 0;
            ab = $urandom_range(0, 3) == 0;
            wrb = $urandom_range(0, 2) == 0;
            mrb = $urandom_range(0, 2) == 0;
            arb = $urandom_range(0, 2) == 0;
        end
        cyc(); rstn = 1;
        @(negedge clk);
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
